uart_tx: RTL and testbench

Byte-serialising UART transmitter, the transmit-side counterpart of `uart_rx` on the same serial link. It accepts a parallel payload through an enable strobe and drives an asynchronous serial frame: start bit, LSB-first data, optional parity, stop bit(s). It can also emit a line break. It sits beside `uart_rx` in the peripheral block and shares its bit-rate and clock parameters, so a loopback (`uart_txd` → `uart_rxd`) is bit-exact.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_bit_timer.sv | 29 ++
 rtl/uart_tx.sv | 108 ++++++++++
 tb/tb_uart_tx.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive sides: FSM states,
// parity codes and the bit-period calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts CPB clocks and pulses bit_done on the last one.
// Holding restart keeps the count at zero so the first period starts cleanly.
module uart_bit_timer #(
  parameter int CPB = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);

  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CPB - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_done = !restart && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, optional parity, stop bit(s),
// plus a line-break generator. Line and busy are registered copies of the FSM view.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 48000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic                    uart_tx_break,
  output logic                    uart_txd,
  output logic                    uart_tx_busy
);

  localparam int CPB        = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int FRAME_BITS = 1 + PAYLOAD_BITS + ((PARITY != PARITY_NONE) ? 1 : 0) + STOP_BITS;

  uart_state_t             r_state, w_state_next;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic [3:0]              r_bit_cnt;
  logic                    r_parity;
  logic                    r_txd, r_busy;
  logic                    w_txd, w_restart, w_bit_done;

  uart_bit_timer #(.CPB(CPB)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (w_restart),
    .bit_done (w_bit_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_txd        = 1'b1;
    w_restart    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_restart = 1'b1;
        if (uart_tx_en)         w_state_next = ST_START;
        else if (uart_tx_break) w_state_next = ST_BREAK;
      end
      ST_START: begin
        w_txd = 1'b0;
        if (w_bit_done) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        w_txd = r_shift[0];
        if (w_bit_done && (r_bit_cnt == 4'(PAYLOAD_BITS - 1)))
          w_state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        w_txd = r_parity;
        if (w_bit_done) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_done && (r_bit_cnt == 4'(STOP_BITS - 1))) w_state_next = ST_IDLE;
      end
      ST_BREAK: begin
        // Low for a whole frame's worth of bits, then one bit of mark.
        w_txd = (r_bit_cnt == 4'(FRAME_BITS));
        if (w_bit_done && (r_bit_cnt == 4'(FRAME_BITS))) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_bit_cnt <= '0;
      if (uart_tx_en) begin
        r_shift  <= uart_tx_data;
        r_parity <= (^uart_tx_data) ^ (PARITY == PARITY_ODD);
      end
    end else if (w_bit_done) begin
      r_bit_cnt <= (w_state_next != r_state) ? 4'd0 : r_bit_cnt + 4'd1;
      if (r_state == ST_DATA) r_shift <= r_shift >> 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txd  <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_txd  <= w_txd;
      r_busy <= (r_state != ST_IDLE);
    end
  end

  assign uart_txd     = r_txd;
  assign uart_tx_busy = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CPB = 10 (1000 Hz clock, 100 bit/s), with
// no-parity, even-parity and odd-parity instances driven from shared inputs.
module tb_uart_tx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [7:0] data = 8'h00;
  logic       brk = 1'b0;
  logic       txd0, busy0, txde, busye, txdo, busyo;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx #(.BIT_RATE(100), .CLK_HZ(1000), .PAYLOAD_BITS(8), .STOP_BITS(1), .PARITY(0)) dut (
    .clk(clk), .reset(reset), .uart_tx_en(en), .uart_tx_data(data),
    .uart_tx_break(brk), .uart_txd(txd0), .uart_tx_busy(busy0));

  uart_tx #(.BIT_RATE(100), .CLK_HZ(1000), .PAYLOAD_BITS(8), .STOP_BITS(1), .PARITY(2)) dut_e (
    .clk(clk), .reset(reset), .uart_tx_en(en), .uart_tx_data(data),
    .uart_tx_break(brk), .uart_txd(txde), .uart_tx_busy(busye));

  uart_tx #(.BIT_RATE(100), .CLK_HZ(1000), .PAYLOAD_BITS(8), .STOP_BITS(1), .PARITY(1)) dut_o (
    .clk(clk), .reset(reset), .uart_tx_en(en), .uart_tx_data(data),
    .uart_tx_break(brk), .uart_txd(txdo), .uart_tx_busy(busyo));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Caller sits just after accept edge N; sample i is taken at the negedge after edge N+i.
  // Line bit j (0 = start) is expected during samples 1+j*CPB .. (j+1)*CPB.
  task automatic run_frame(input string tag, input int sel, input logic [15:0] bits,
                           input int nbits, input int busy_len, input int ncyc);
    int   n_txd_bad, n_busy, n_busy_bad;
    logic t, b, et, eb;
    n_txd_bad = 0; n_busy = 0; n_busy_bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      t  = (sel == 0) ? txd0  : (sel == 1) ? txde  : txdo;
      b  = (sel == 0) ? busy0 : (sel == 1) ? busye : busyo;
      et = (i >= 1 && i <= nbits * CPB) ? bits[(i - 1) / CPB] : 1'b1;
      eb = (i >= 1 && i <= busy_len);
      if (t !== et) n_txd_bad++;
      if (b !== eb) n_busy_bad++;
      if (b === 1'b1) n_busy++;
    end
    chk({tag, "_txd_bad"}, n_txd_bad, 0);
    chk({tag, "_busy_cyc"}, n_busy, busy_len);
    chk({tag, "_busy_bad"}, n_busy_bad, 0);
  endtask

  task automatic accept(input logic [7:0] d);
    @(negedge clk);
    en   = 1'b1;
    data = d;
    @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", txd0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_txd_par", txde, 1'b1);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 8'hAA, no parity: line 0,0,1,0,1,0,1,0,1,1
    accept(8'hAA);
    #1 en = 1'b0;
    run_frame("aa", 0, {6'b0, 1'b1, 8'hAA, 1'b0}, 10, 10 * CPB, 12 * CPB);

    // 8'h0A has two ones: even parity bit 0, odd parity bit 1
    accept(8'h0A);
    #1 en = 1'b0;
    run_frame("par_even", 1, {5'b0, 1'b1, 1'b0, 8'h0A, 1'b0}, 11, 11 * CPB, 12 * CPB);
    accept(8'h0A);
    #1 en = 1'b0;
    run_frame("par_odd", 2, {5'b0, 1'b1, 1'b1, 8'h0A, 1'b0}, 11, 11 * CPB, 12 * CPB);

    // Back-to-back with en held: 8'h55 then 8'hC3, one idle cycle between,
    // and a mid-frame request with 8'hFF must not start a third frame.
    accept(8'h55);
    #1 data = 8'hC3;
    run_frame("b2b_1", 0, {6'b0, 1'b1, 8'h55, 1'b0}, 10, 10 * CPB, 10 * CPB + 1);
    fork
      run_frame("b2b_2", 0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10, 10 * CPB, 13 * CPB);
      begin
        @(posedge clk);
        #1 en = 1'b0;
        repeat (40) @(posedge clk);
        #1 begin en = 1'b1; data = 8'hFF; end
        @(posedge clk);
        #1 en = 1'b0;
      end
    join

    // Payload change one cycle after accept must not reach the line.
    accept(8'h0F);
    fork
      run_frame("hold", 0, {6'b0, 1'b1, 8'h0F, 1'b0}, 10, 10 * CPB, 12 * CPB);
      begin
        #1 en = 1'b0;
        @(posedge clk);
        #1 data = 8'hF0;
      end
    join

    // Break: low 10 bit times, mark 1 bit time, busy 11 bit times.
    @(negedge clk);
    brk = 1'b1;
    @(posedge clk);
    #1 brk = 1'b0;
    run_frame("brk", 0, {5'b0, 1'b1, 10'b0}, 11, 11 * CPB, 12 * CPB);

    // Reset mid data bit 3 of 8'hA5 (bit 3 is 0): line must jump high at once.
    accept(8'hA5);
    #1 en = 1'b0;
    repeat (44) @(posedge clk);
    #1 chk("pre_rst_txd", txd0, 1'b0);
    chk("pre_rst_busy", busy0, 1'b1);
    #1 reset = 1'b1;
    #1 chk("async_rst_txd", txd0, 1'b1);
    chk("async_rst_busy", busy0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    accept(8'h3C);
    #1 en = 1'b0;
    run_frame("post_rst", 0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 10 * CPB, 12 * CPB);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
